// File: rtl/nibble_serial_alu.sv
// Nibble-serial ADD/SUB/CMP/PASS unit: one shared 4-bit adder and comparator are
// reused across WIDTH-bit operands, LSB nibble first, behind valid/ready ports.
module nibble_serial_alu #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic [2:0]       cmp_gel,
    output logic             busy
);

    localparam int unsigned NIB  = WIDTH / 4;
    localparam int unsigned IdxW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NIB - 1);

    localparam logic [1:0] OpAdd  = 2'b00;
    localparam logic [1:0] OpSub  = 2'b01;
    localparam logic [1:0] OpCmp  = 2'b10;
    localparam logic [1:0] OpPass = 2'b11;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e state_q, state_d;

    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q;
    logic [IdxW-1:0]  idx_q;
    logic             carry_q;
    logic [2:0]       gel_q;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic [2:0]       cmp_gel_q;

    logic             accept;
    logic             last_nib;
    logic [3:0]       a_nib, b_nib, b_eff;
    logic [4:0]       sum;
    logic [2:0]       gel_next;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] result_d;
    logic             cout_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid)            state_d = StBusy;
            StBusy:  if (idx_q == LastIdx)    state_d = StDone;
            StDone:  if (out_ready)           state_d = StIdle;
            default:                          state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
    end

    assign accept   = in_valid && in_ready;
    assign last_nib = (idx_q == LastIdx);

    // Shared nibble datapath; SUB adds ~b with an initial carry of 1
    always_comb begin
        a_nib    = a_q[{idx_q, 2'b00} +: 4];
        b_nib    = b_q[{idx_q, 2'b00} +: 4];
        b_eff    = (op_q == OpSub) ? ~b_nib : b_nib;
        sum      = {1'b0, a_nib} + {1'b0, b_eff} + {4'b0000, carry_q};
        gel_next = gel_q;
        if (a_nib > b_nib) begin
            gel_next = 3'b100;
        end else if (a_nib < b_nib) begin
            gel_next = 3'b001;
        end
        acc_next = acc_q;
        acc_next[{idx_q, 2'b00} +: 4] = sum[3:0];
    end

    always_comb begin
        result_d = '0;
        cout_d   = 1'b0;
        unique case (op_q)
            OpAdd, OpSub: begin
                result_d = acc_next;
                cout_d   = sum[4];
            end
            OpCmp: begin
                result_d = '0;
                cout_d   = 1'b0;
            end
            OpPass: begin
                result_d = a_q;
                cout_d   = 1'b0;
            end
            default: begin
                result_d = '0;
                cout_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= OpAdd;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            gel_q     <= 3'b010;
            result_q  <= '0;
            cout_q    <= 1'b0;
            cmp_gel_q <= 3'b000;
        end else if (accept) begin
            op_q    <= op;
            a_q     <= a;
            b_q     <= b;
            acc_q   <= '0;
            idx_q   <= '0;
            carry_q <= (op == OpAdd) ? cin : (op == OpSub);
            gel_q   <= 3'b010;
        end else if (state_q == StBusy) begin
            idx_q   <= idx_q + 1'b1;
            carry_q <= sum[4];
            gel_q   <= gel_next;
            acc_q   <= acc_next;
            if (last_nib) begin
                result_q  <= result_d;
                cout_q    <= cout_d;
                cmp_gel_q <= gel_next;
            end
        end
    end

    assign result  = result_q;
    assign cout    = cout_q;
    assign cmp_gel = cmp_gel_q;

endmodule

// File: tb/tb_nibble_serial_alu.sv
// Directed and randomized checks of nibble_serial_alu against a whole-word arithmetic
// reference model, including latency, DONE hold-off and mid-operation reset.
module tb_nibble_serial_alu;

    localparam int unsigned W   = 16;
    localparam int unsigned NIB = W / 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic [2:0]   cmp_gel;
    logic         busy;

    int vectors;
    int miscompares;

    nibble_serial_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .cmp_gel   (cmp_gel),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Whole-word reference: plain arithmetic on full operands
    task automatic model(input logic [1:0] m_op, input logic [W-1:0] m_a, input logic [W-1:0] m_b,
                         input logic m_cin, output logic [W-1:0] m_r, output logic m_c,
                         output logic [2:0] m_g);
        int unsigned s;
        m_g = (m_a > m_b) ? 3'b100 : ((m_a == m_b) ? 3'b010 : 3'b001);
        case (m_op)
            2'b00: begin
                s   = int'(m_a) + int'(m_b) + int'(m_cin);
                m_r = s[W-1:0];
                m_c = s[W];
            end
            2'b01: begin
                m_r = m_a - m_b;
                m_c = (m_a >= m_b);
            end
            2'b10: begin
                m_r = '0;
                m_c = 1'b0;
            end
            default: begin
                m_r = m_a;
                m_c = 1'b0;
            end
        endcase
    endtask

    task automatic run_op(input string tag, input logic [1:0] t_op, input logic [W-1:0] t_a,
                          input logic [W-1:0] t_b, input logic t_cin, input int hold);
        logic [W-1:0] er;
        logic         ec;
        logic [2:0]   eg;
        int           n;
        model(t_op, t_a, t_b, t_cin, er, ec, eg);
        @(negedge clk);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op       = t_op;
        a        = t_a;
        b        = t_b;
        cin      = t_cin;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        cin      = 1'($urandom);
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk({tag, ".latency"}, 32'(n), 32'(NIB));
        chk({tag, ".result"}, 32'(result), 32'(er));
        chk({tag, ".cout"}, 32'(cout), 32'(ec));
        chk({tag, ".gel"}, 32'(cmp_gel), 32'(eg));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            op       = 2'($urandom);
            a        = W'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
            chk({tag, ".hold_result"}, 32'(result), 32'(er));
            chk({tag, ".hold_gel"}, 32'(cmp_gel), 32'(eg));
            chk({tag, ".hold_cout"}, 32'(cout), 32'(ec));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".post_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".post_ready"}, 32'(in_ready), 32'd1);
        chk({tag, ".post_result"}, 32'(result), 32'(er));
    endtask

    initial begin
        int seen;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        op          = 2'b00;
        a           = '0;
        b           = '0;
        cin         = 1'b0;
        #1;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.result", 32'(result), 32'd0);
        chk("rst.cout", 32'(cout), 32'd0);
        chk("rst.gel", 32'(cmp_gel), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add_5_15", 2'b00, 16'd5, 16'd15, 1'b1, 0);
        chk("add_5_15.const", 32'(result), 32'h0015);
        run_op("add_ripple", 2'b00, 16'hFFFF, 16'h0001, 1'b0, 0);
        chk("add_ripple.cout", 32'(cout), 32'd1);
        run_op("cmp_33_12", 2'b10, 16'd33, 16'd12, 1'b1, 0);
        chk("cmp_33_12.const", 32'(cmp_gel), 32'b100);
        run_op("cmp_33_91", 2'b10, 16'd33, 16'd91, 1'b0, 0);
        run_op("cmp_7_7", 2'b10, 16'd7, 16'd7, 1'b0, 0);
        run_op("cmp_top", 2'b10, 16'h1200, 16'h0FFF, 1'b0, 0);
        chk("cmp_top.const", 32'(cmp_gel), 32'b100);
        run_op("sub_4_7", 2'b01, 16'd4, 16'd7, 1'b1, 0);
        chk("sub_4_7.const", 32'(result), 32'hFFFD);
        run_op("sub_7_4", 2'b01, 16'd7, 16'd4, 1'b0, 0);
        run_op("pass", 2'b11, 16'hBEEF, 16'h1234, 1'b1, 0);
        run_op("hold5", 2'b00, 16'h1234, 16'h4321, 1'b0, 5);
        run_op("b2b", 2'b01, 16'h8000, 16'h0001, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
            run_op("rand", 2'($urandom), ra, rb, 1'($urandom), int'($urandom_range(0, 2)));
        end

        // Leave a nonzero result so the reset clear is observable
        run_op("pre_rst", 2'b00, 16'h00F0, 16'h0F0F, 1'b0, 0);
        @(negedge clk);
        in_valid = 1'b1;
        op       = 2'b00;
        a        = 16'h1234;
        b        = 16'h1111;
        cin      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst.out_valid", 32'(out_valid), 32'd0);
        chk("midrst.result", 32'(result), 32'd0);
        chk("midrst.gel", 32'(cmp_gel), 32'd0);
        chk("midrst.busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        chk("midrst.no_completion", 32'(seen), 32'd0);
        run_op("after_rst", 2'b00, 16'd4, 16'd7, 1'b0, 0);
        chk("after_rst.const", 32'(result), 32'd11);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
